operand_fetch_stage: RTL and testbench
======================================

// Module: operand_fetch_stage
// PURPOSE
//   Register-read stage between decode and execute. Accepts a decoded instruction
//   and drives the register-file read addresses. Bypasses the same-cycle writeback
//   value and stalls on long-latency (load/mul) results that are still pending.
//   Presents registered operands to execute over a valid/ready pipeline register.
// PARAMETERS
//   XLEN    32  operand / register data width
//   CTRL_W  8   width of opaque control bundle passed through to execute
// PORTS
//   clk            in   1       clock
//   rst_n          in   1       reset, asynchronous, active-low
//   flush          in   1       kill input and output-register contents
//   in_valid       in   1       decode presents an instruction
//   in_ready       out  1       stage accepts instruction this cycle (combinational)
//   in_rs1         in   5       source register 1
//   in_rs2         in   5       source register 2
//   in_rd          in   5       destination register
//   in_rd_we       in   1       instruction writes in_rd
//   in_long        in   1       in_rd is produced by a long-latency unit
//   in_ctrl        in   CTRL_W  control bundle, passed through unchanged
//   rf_read_addr1  out  5       = in_rs1 (combinational)
//   rf_read_addr2  out  5       = in_rs2 (combinational)
//   rf_read_data1  in   XLEN    register-file async read data, port 1
//   rf_read_data2  in   XLEN    register-file async read data, port 2
//   wb_en          in   1       writeback this cycle (same signal as the RF write enable)
//   wb_addr        in   5       writeback register
//   wb_data        in   XLEN    writeback data
//   wb_long_done   in   1       this writeback completes a long-latency op
//   out_valid      out  1       execute payload valid (registered)
//   out_ready      in   1       execute accepts payload
//   out_op1        out  XLEN    operand 1 (registered)
//   out_op2        out  XLEN    operand 2 (registered)
//   out_rd         out  5       destination (registered)
//   out_rd_we      out  1       destination write enable (registered)
//   out_long       out  1       long-latency flag (registered)
//   out_ctrl       out  CTRL_W  control (registered)
// BEHAVIOUR
//   - Reset: out_valid=0. All out_* data are 0. The scoreboard sb[31:0] is 0.
//   - Operand select per source rs: rs==0 -> 0 (the RF does not guarantee x0=0).
//     Else if wb_en && wb_addr==rs -> wb_data (bypass). Else rf_read_data.
//   - Pending(rs) = rs!=0 && (sb[rs] || (out_valid && out_rd_we && out_long && out_rd==rs)).
//   - Exception to Pending: if wb_en && wb_long_done && wb_addr==rs this cycle, the source
//     is not pending. Its operand comes from the bypass.
//   - hazard = Pending(rs1) || Pending(rs2).
//   - Output register: can_load = !out_valid || out_ready.
//     in_ready = can_load && !hazard && !flush.
//   - Accept (in_valid && in_ready): load out_* next edge and set out_valid=1.
//     Latency is 1 cycle from accept to out_valid.
//   - When out_valid && out_ready and no accept occurs: out_valid goes to 0 next edge.
//     Data holds its previous value.
//   - While out_valid && !out_ready, all out_* hold stable.
//   - flush: out_valid goes to 0 next edge. No accept that cycle. Scoreboard is untouched.
//   - Scoreboard set: on out_valid && out_ready && out_rd_we && out_long && out_rd!=0,
//     set sb[out_rd].
//   - Scoreboard clear: on wb_en && wb_long_done && wb_addr!=0, clear sb[wb_addr].
//   - Set and clear of the same index in one cycle: set wins.
//   - wb to x0 is never bypassed and never affects sb.
//   - rs1==rs2 is legal; both operands get identical values.
//   - Reset asserted mid-operation: everything returns to reset values. Any in-flight
//     long op is forgotten.
// CONFIGURATION
//   OF_BYPASS_EN defined (default build):
//     - writeback bypass as described above.
//   OF_BYPASS_EN undefined:
//     - no bypass mux; operands come only from rf_read_data (x0 is still forced to 0).
//     - Extra stall term: wb_en && wb_addr!=0 && wb_addr==rs (either source).
//     - A completing long op also stalls 1 cycle and reads the RF on the following cycle.
// TESTING
//   1. Reset then idle, RF x5=7: in rs1=5,rs2=0 -> next cycle out_valid=1, op1=7, op2=0.
//   2. RF x3=1 with same-cycle wb_en x3=0xAA, issue rs1=3 -> op1=0xAA, no stall.
//      With OF_BYPASS_EN undefined: 1-cycle stall, then op1=0xAA.
//   3. Load rd=4 leaves the stage; next instruction uses rs2=4:
//      - in_ready=0 until wb_en,wb_long_done,wb_addr=4,wb_data=0x55 arrive.
//      - Accepted that cycle with op2=0x55 (bypass build).
//   4. out_ready=0 for 3 cycles with out_valid=1: out_* stable, in_ready=0.
//      Raise out_ready -> back-to-back accepts, 1 instruction per cycle.
//   5. Long op rd=6 held in the output register, then flush:
//      - out_valid=0 next cycle, sb[6] stays 0.
//      - A following rs1=6 instruction issues with no stall.
//   6. rs1=0 while RF x0=0x123 and wb_en x0=0x9 -> op1=0, sb unchanged.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// ---------------------------------------------------------------------------
// operand_fetch_stage
//
// Register-read stage between decode and execute. It drives the register-file
// read addresses straight from the decoded sources. It forces x0 to zero, and
// it stalls while a source is still owed by a long-latency (load/mul) unit.
// The chosen operands and the pass-through control are presented to execute
// through a single valid/ready output register.
//
// Build option:
//   OF_BYPASS_EN  defined   : same-cycle writeback data is bypassed into the
//                             operands. A completing long op is consumed in the
//                             same cycle it writes back.
//   OF_BYPASS_EN  undefined : operands come only from the register file. A
//                             source being written back this cycle stalls for
//                             one cycle and is read from the RF on the next.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      kill the incoming instruction and the output register
//   in_valid / in_ready        decode handshake (in_ready is combinational)
//   in_rs1, in_rs2, in_rd      register indices of the decoded instruction
//   in_rd_we, in_long          destination write enable / long-latency producer
//   in_ctrl                    opaque control bundle passed through unchanged
//   rf_read_addr1/2            register-file read addresses (= in_rs1/in_rs2)
//   rf_read_data1/2            register-file asynchronous read data
//   wb_en, wb_addr, wb_data    writeback port (shared with the RF write port)
//   wb_long_done               this writeback completes a long-latency op
//   out_valid / out_ready      execute handshake
//   out_op1, out_op2, out_rd,
//   out_rd_we, out_long,
//   out_ctrl                   registered payload to execute
// ---------------------------------------------------------------------------
module operand_fetch_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_rd_we,
    input  logic              in_long,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [4:0]        rf_read_addr1,
    output logic [4:0]        rf_read_addr2,
    input  logic [XLEN-1:0]   rf_read_data1,
    input  logic [XLEN-1:0]   rf_read_data2,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              wb_long_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_op1,
    output logic [XLEN-1:0]   out_op2,
    output logic [4:0]        out_rd,
    output logic              out_rd_we,
    output logic              out_long,
    output logic [CTRL_W-1:0] out_ctrl
);

    // Scoreboard: one bit per register whose long-latency result is still owed.
    logic [31:0]       sb_q, sb_d;

    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_op1_q, out_op1_d;
    logic [XLEN-1:0]   out_op2_q, out_op2_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic              out_rd_we_q, out_rd_we_d;
    logic              out_long_q, out_long_d;
    logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;

    logic              inflight_long;
    logic              pend1, pend2;
    logic              wbhit1, wbhit2;
    logic              hazard;
    logic              can_load;
    logic              accept;
    logic [XLEN-1:0]   op1, op2;

`ifdef OF_BYPASS_EN
    logic              done1, done2;
`else
    // Without the bypass the writeback data reaches this stage only through
    // the register file on the following cycle.
    logic              wb_data_unused;
    assign wb_data_unused = ^wb_data;
`endif

    assign rf_read_addr1 = in_rs1;
    assign rf_read_addr2 = in_rs2;

    // Hazard detection and operand selection.
    always_comb begin
        // A long op sitting in the output register is not on the scoreboard yet,
        // but a consumer behind it must already wait for it.
        inflight_long = out_valid_q && out_rd_we_q && out_long_q;

        pend1 = (in_rs1 != 5'd0) &&
                (sb_q[in_rs1] || (inflight_long && (out_rd_q == in_rs1)));
        pend2 = (in_rs2 != 5'd0) &&
                (sb_q[in_rs2] || (inflight_long && (out_rd_q == in_rs2)));

        // Writes to x0 are ignored throughout, so a hit requires a nonzero index.
        wbhit1 = wb_en && (wb_addr != 5'd0) && (wb_addr == in_rs1);
        wbhit2 = wb_en && (wb_addr != 5'd0) && (wb_addr == in_rs2);

`ifdef OF_BYPASS_EN
        // The completing writeback satisfies the dependency via the bypass mux.
        done1  = wbhit1 && wb_long_done;
        done2  = wbhit2 && wb_long_done;
        hazard = (pend1 && !done1) || (pend2 && !done2);
        op1    = (in_rs1 == 5'd0) ? '0 : (wbhit1 ? wb_data : rf_read_data1);
        op2    = (in_rs2 == 5'd0) ? '0 : (wbhit2 ? wb_data : rf_read_data2);
`else
        hazard = pend1 || pend2 || wbhit1 || wbhit2;
        op1    = (in_rs1 == 5'd0) ? '0 : rf_read_data1;
        op2    = (in_rs2 == 5'd0) ? '0 : rf_read_data2;
`endif

        can_load = !out_valid_q || out_ready;
        in_ready = can_load && !hazard && !flush;
        accept   = in_valid && in_ready;
    end

    // Output register and scoreboard next state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_op1_d   = out_op1_q;
        out_op2_d   = out_op2_q;
        out_rd_d    = out_rd_q;
        out_rd_we_d = out_rd_we_q;
        out_long_d  = out_long_q;
        out_ctrl_d  = out_ctrl_q;
        sb_d        = sb_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // accept is already gated by flush through in_ready.
        if (accept) begin
            out_op1_d   = op1;
            out_op2_d   = op2;
            out_rd_d    = in_rd;
            out_rd_we_d = in_rd_we;
            out_long_d  = in_long;
            out_ctrl_d  = in_ctrl;
        end

        // Clear first so that a set of the same index in this cycle wins.
        if (wb_en && wb_long_done && (wb_addr != 5'd0)) begin
            sb_d[wb_addr] = 1'b0;
        end
        if (out_valid_q && out_ready && out_rd_we_q && out_long_q && (out_rd_q != 5'd0)) begin
            sb_d[out_rd_q] = 1'b1;
        end
    end

    // Stage boundary: output register to execute.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q        <= '0;
            out_valid_q <= 1'b0;
            out_op1_q   <= '0;
            out_op2_q   <= '0;
            out_rd_q    <= '0;
            out_rd_we_q <= 1'b0;
            out_long_q  <= 1'b0;
            out_ctrl_q  <= '0;
        end else begin
            sb_q        <= sb_d;
            out_valid_q <= out_valid_d;
            out_op1_q   <= out_op1_d;
            out_op2_q   <= out_op2_d;
            out_rd_q    <= out_rd_d;
            out_rd_we_q <= out_rd_we_d;
            out_long_q  <= out_long_d;
            out_ctrl_q  <= out_ctrl_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op1   = out_op1_q;
    assign out_op2   = out_op2_q;
    assign out_rd    = out_rd_q;
    assign out_rd_we = out_rd_we_q;
    assign out_long  = out_long_q;
    assign out_ctrl  = out_ctrl_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch_stage
//
// Directed bench for operand_fetch_stage. A small register-file model drives
// the asynchronous read ports and absorbs writebacks on the clock edge.
// Accepted instructions push their expected payload into a queue. Each
// output handshake pops the queue and compares the payload.
// ---------------------------------------------------------------------------
module tb_operand_fetch_stage;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;

    typedef struct packed {
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [4:0]        rd;
        logic              rd_we;
        logic              lng;
        logic [CTRL_W-1:0] ctrl;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_rs1, in_rs2, in_rd;
    logic              in_rd_we, in_long;
    logic [CTRL_W-1:0] in_ctrl;
    logic [4:0]        rf_read_addr1, rf_read_addr2;
    logic [XLEN-1:0]   rf_read_data1, rf_read_data2;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              wb_long_done;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_op1, out_op2;
    logic [4:0]        out_rd;
    logic              out_rd_we, out_long;
    logic [CTRL_W-1:0] out_ctrl;

    logic [XLEN-1:0]   rf_mem [32];
    exp_t              exp_q[$];
    exp_t              cur_exp;
    int                vectors;
    int                miscompares;

    operand_fetch_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rd_we(in_rd_we), .in_long(in_long), .in_ctrl(in_ctrl),
        .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_long_done(wb_long_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_long(out_long), .out_ctrl(out_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: asynchronous read, writeback on the clock edge, x0 not written.
    assign rf_read_data1 = rf_mem[rf_read_addr1];
    assign rf_read_data2 = rf_mem[rf_read_addr2];
    always @(posedge clk) begin
        if (wb_en && wb_addr != 5'd0) rf_mem[wb_addr] <= wb_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic present(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic we, input logic lng, input logic [CTRL_W-1:0] ctrl,
                           input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2);
        in_valid = 1'b1;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
        in_rd_we = we;
        in_long  = lng;
        in_ctrl  = ctrl;
        cur_exp  = '{op1: e1, op2: e2, rd: rd, rd_we: we, lng: lng, ctrl: ctrl};
    endtask

    // One clock: score the output handshake and record an accept, then advance.
    task automatic tick();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_out observed=out_valid expected=no pending payload");
            end else begin
                e = exp_q.pop_front();
                chk("out_op1",   64'(out_op1),   64'(e.op1));
                chk("out_op2",   64'(out_op2),   64'(e.op2));
                chk("out_rd",    64'(out_rd),    64'(e.rd));
                chk("out_rd_we", 64'(out_rd_we), 64'(e.rd_we));
                chk("out_long",  64'(out_long),  64'(e.lng));
                chk("out_ctrl",  64'(out_ctrl),  64'(e.ctrl));
            end
        end
        if (in_valid && in_ready) exp_q.push_back(cur_exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_rs1       = '0;
        in_rs2       = '0;
        in_rd        = '0;
        in_rd_we     = 1'b0;
        in_long      = 1'b0;
        in_ctrl      = '0;
        wb_en        = 1'b0;
        wb_addr      = '0;
        wb_data      = '0;
        wb_long_done = 1'b0;
        out_ready    = 1'b1;
        cur_exp      = '0;
        for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h1000 + 32'(i);
        rf_mem[0] <= 32'h123;
        rf_mem[3] <= 32'h1;
        rf_mem[5] <= 32'h7;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_op1",   64'(out_op1),   64'(0));
        chk("rst_out_op2",   64'(out_op2),   64'(0));
        chk("rst_out_rd",    64'(out_rd),    64'(0));
        chk("rst_out_flags", 64'({out_rd_we, out_long}), 64'(0));
        chk("rst_out_ctrl",  64'(out_ctrl),  64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: plain read, x5=7, rs2=x0
        present(5'd5, 5'd0, 5'd1, 1'b1, 1'b0, 8'h11, 32'h7, 32'h0);
        settle();
        chk("t1_in_ready", 64'(in_ready), 64'(1));
        chk("t1_rf_addr1", 64'(rf_read_addr1), 64'(5));
        tick();
        in_valid = 1'b0;
        chk("t1_latency", 64'(out_valid), 64'(1));
        tick();

        // 2: same-cycle writeback of x3
        present(5'd3, 5'd0, 5'd2, 1'b1, 1'b0, 8'h22, 32'hAA, 32'h0);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hAA; wb_long_done = 1'b0;
        settle();
`ifdef OF_BYPASS_EN
        chk("t2_in_ready_bypass", 64'(in_ready), 64'(1));
        tick();
        wb_en = 1'b0;
`else
        chk("t2_in_ready_stall", 64'(in_ready), 64'(0));
        tick();
        wb_en = 1'b0;
        settle();
        chk("t2_in_ready_after", 64'(in_ready), 64'(1));
        tick();
`endif
        in_valid = 1'b0;
        tick();

        // 3: load to x4 followed by a consumer of x4
        present(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 8'h33, 32'h0, 32'h0);
        tick();
        present(5'd0, 5'd4, 5'd7, 1'b1, 1'b0, 8'h3C, 32'h0, 32'h55);
        settle();
        chk("t3_stall_outreg", 64'(in_ready), 64'(0));
        tick();
        settle();
        chk("t3_stall_sb", 64'(in_ready), 64'(0));
        tick();
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h55; wb_long_done = 1'b1;
        settle();
`ifdef OF_BYPASS_EN
        chk("t3_accept_on_wb", 64'(in_ready), 64'(1));
        tick();
        wb_en = 1'b0; wb_long_done = 1'b0;
`else
        chk("t3_stall_on_wb", 64'(in_ready), 64'(0));
        tick();
        wb_en = 1'b0; wb_long_done = 1'b0;
        settle();
        chk("t3_accept_after_wb", 64'(in_ready), 64'(1));
        tick();
`endif
        in_valid = 1'b0;
        tick();

        // 4: back-pressure for 3 cycles, then back-to-back accepts
        out_ready = 1'b0;
        present(5'd5, 5'd3, 5'd8, 1'b1, 1'b0, 8'h44, 32'h7, 32'hAA);
        tick();
        present(5'd2, 5'd2, 5'd9, 1'b1, 1'b0, 8'h55, 32'h1002, 32'h1002);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t4_hold_in_ready",  64'(in_ready),  64'(0));
            chk("t4_hold_out_valid", 64'(out_valid), 64'(1));
            chk("t4_hold_op1",       64'(out_op1),   64'(32'h7));
            chk("t4_hold_op2",       64'(out_op2),   64'(32'hAA));
            chk("t4_hold_ctrl",      64'(out_ctrl),  64'(8'h44));
            tick();
        end
        out_ready = 1'b1;
        settle();
        chk("t4_b2b_ready0", 64'(in_ready), 64'(1));
        tick();
        present(5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 8'h66, 32'h100A, 32'h0);
        settle();
        chk("t4_b2b_ready1", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        tick();

        // 5: long op to x6 flushed from the output register
        out_ready = 1'b0;
        present(5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 8'h77, 32'h0, 32'h0);
        tick();
        in_valid = 1'b0;
        settle();
        chk("t5_held", 64'(out_valid), 64'(1));
        flush = 1'b1;
        settle();
        chk("t5_flush_in_ready", 64'(in_ready), 64'(0));
        tick();
        flush = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        settle();
        chk("t5_flushed", 64'(out_valid), 64'(0));
        out_ready = 1'b1;
        present(5'd6, 5'd0, 5'd11, 1'b1, 1'b0, 8'h88, 32'h1006, 32'h0);
        settle();
        chk("t5_no_stall", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        tick();

        // 6: x0 forced to zero, writeback to x0 ignored
        present(5'd0, 5'd5, 5'd13, 1'b1, 1'b0, 8'h99, 32'h0, 32'h7);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h9; wb_long_done = 1'b1;
        settle();
        chk("t6_rf_addr2", 64'(rf_read_addr2), 64'(5));
        chk("t6_in_ready", 64'(in_ready), 64'(1));
        tick();
        wb_en = 1'b0; wb_long_done = 1'b0;
        present(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'h9A, 32'h0, 32'h0);
        tick();
        in_valid = 1'b0;
        tick();

        // 7: reset while a long op to x12 is outstanding
        present(5'd5, 5'd0, 5'd12, 1'b1, 1'b1, 8'hAB, 32'h7, 32'h0);
        tick();
        in_valid = 1'b0;
        tick();
        settle();
        chk("t7_drained", 64'(out_valid), 64'(0));
        chk("t7_data_hold", 64'(out_op1), 64'(32'h7));
        present(5'd12, 5'd0, 5'd14, 1'b0, 1'b0, 8'hCD, 32'h100C, 32'h0);
        settle();
        chk("t7_sb_stall", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", 64'(out_valid), 64'(0));
        chk("t7_rst_op1",   64'(out_op1),   64'(0));
        chk("t7_rst_ctrl",  64'(out_ctrl),  64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        present(5'd12, 5'd0, 5'd14, 1'b0, 1'b0, 8'hCD, 32'h100C, 32'h0);
        settle();
        chk("t7_sb_forgotten", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        tick();

        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
